taxi_basex_link_mon: RTL and testbench

Per-port link monitor for a 1000BASE-X PCS/PMA. It consumes the 16-bit PCS status vector and the GMII rx_dv/tx_en strobes, and produces:
- a qualified link-up indication with up/down event pulses;
- a saturating link-flap counter;
- sticky error flags;
- an activity-stretched LED pair.

One instance sits beside each SFP PCS/PMA, between the status vector and the board LED/CSR logic.

---
 rtl/taxi_basex_link_mon_pkg.sv | 28 ++
 rtl/taxi_pulse_stretch.sv | 38 +++
 rtl/taxi_sync_signal.sv | 25 ++
 rtl/taxi_basex_link_mon.sv | 153 +++++++++++++++
 tb/tb_taxi_basex_link_mon.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/taxi_basex_link_mon_pkg.sv
// Shared types and constants for the 1000BASE-X link monitor.
package taxi_basex_link_mon_pkg;

  typedef enum logic [1:0] {
    ST_DOWN = 2'd0,
    ST_QUAL = 2'd1,
    ST_UP   = 2'd2
  } link_state_t;

  // Bit positions inside the PCS status vector
  localparam int STAT_LINK       = 0;
  localparam int STAT_RUDI_INV   = 4;
  localparam int STAT_DISPERR    = 5;
  localparam int STAT_NOTINTABLE = 6;

  // Bit positions inside err_sticky
  localparam int ERR_RUDI_INV   = 0;
  localparam int ERR_DISPERR    = 1;
  localparam int ERR_NOTINTABLE = 2;

  // Bit positions inside the synchronised status bundle
  localparam int SYN_LINK       = 0;
  localparam int SYN_RUDI_INV   = 1;
  localparam int SYN_DISPERR    = 2;
  localparam int SYN_NOTINTABLE = 3;
  localparam int SYN_W          = 4;

endpackage

// File: rtl/taxi_pulse_stretch.sv
// Stretches any strobe to at least LEN cycles; used for LED activity indicators.
module taxi_pulse_stretch #(
  parameter int LEN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LEN_V = CW'(LEN);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Reload on a strobe, otherwise count down and park at zero
  always_comb begin
    cnt_next = cnt;
    if (in) begin
      cnt_next = LEN_V;
    end else if (cnt != '0) begin
      cnt_next = cnt - CW'(1);
    end
  end

  // Output flop follows the next counter value so it rises one cycle after the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      out <= 1'b0;
    end else begin
      cnt <= cnt_next;
      out <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/taxi_sync_signal.sv
// N-stage flop synchronizer for a bundle of slow, independent level signals.
module taxi_sync_signal #(
  parameter int WIDTH = 1,
  parameter int N     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [N-1:0][WIDTH-1:0] sync_reg;

  // Shift the input through N flops; the last stage is the safe copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[N-2:0], in};
    end
  end

  assign out = sync_reg[N-1];

endmodule

// File: rtl/taxi_basex_link_mon.sv
// Per-port 1000BASE-X link monitor: qualified link state, flap counter,
// sticky PCS error flags and activity-stretched LEDs.
module taxi_basex_link_mon
  import taxi_basex_link_mon_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 125000,
  parameter int BLINK_CYCLES   = 6250000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      status_vect,
  input  logic             gmii_rx_dv,
  input  logic             gmii_tx_en,
  input  logic             clear,
  output logic             link_up,
  output logic             link_up_event,
  output logic             link_down_event,
  output logic [CNT_W-1:0] flap_count,
  output logic [2:0]       err_sticky,
  output logic             activity,
  output logic [1:0]       led
);

  localparam int HW = $clog2(HOLDOFF_CYCLES);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLAP_MAX  = '1;

  logic [SYN_W-1:0] stat_raw;
  logic [SYN_W-1:0] stat_sync;
  logic             s_link;
  logic [2:0]       s_err;
  logic             unused_status;

  link_state_t      state;
  logic [HW-1:0]    hold_cnt;
  logic             flap_inc;

  assign stat_raw[SYN_LINK]       = status_vect[STAT_LINK];
  assign stat_raw[SYN_RUDI_INV]   = status_vect[STAT_RUDI_INV];
  assign stat_raw[SYN_DISPERR]    = status_vect[STAT_DISPERR];
  assign stat_raw[SYN_NOTINTABLE] = status_vect[STAT_NOTINTABLE];
  assign unused_status = ^{status_vect[15:7], status_vect[3:1]};

  taxi_sync_signal #(
    .WIDTH(SYN_W),
    .N    (2)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (stat_raw),
    .out  (stat_sync)
  );

  assign s_link                   = stat_sync[SYN_LINK];
  assign s_err[ERR_RUDI_INV]      = stat_sync[SYN_RUDI_INV];
  assign s_err[ERR_DISPERR]       = stat_sync[SYN_DISPERR];
  assign s_err[ERR_NOTINTABLE]    = stat_sync[SYN_NOTINTABLE];

  assign flap_inc = (state == ST_UP) && !s_link;

  // Link FSM; hold_cnt counts cycles with s_link high since leaving DOWN,
  // so the DOWN->QUAL edge already counts as the first one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_DOWN;
      hold_cnt        <= '0;
      link_up         <= 1'b0;
      link_up_event   <= 1'b0;
      link_down_event <= 1'b0;
    end else begin
      link_up_event   <= 1'b0;
      link_down_event <= 1'b0;
      case (state)
        ST_DOWN: begin
          hold_cnt <= '0;
          if (s_link) begin
            state    <= ST_QUAL;
            hold_cnt <= HW'(1);
          end
        end
        ST_QUAL: begin
          if (!s_link) begin
            state    <= ST_DOWN;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state         <= ST_UP;
            hold_cnt      <= '0;
            link_up       <= 1'b1;
            link_up_event <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_UP: begin
          if (!s_link) begin
            state           <= ST_DOWN;
            link_up         <= 1'b0;
            link_down_event <= 1'b1;
          end
        end
        default: begin
          state    <= ST_DOWN;
          hold_cnt <= '0;
          link_up  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating flap counter; a coincident clear restarts the count at the new drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flap_count <= '0;
    end else if (flap_inc) begin
      if (clear) begin
        flap_count <= CNT_W'(1);
      end else if (flap_count != FLAP_MAX) begin
        flap_count <= flap_count + CNT_W'(1);
      end
    end else if (clear) begin
      flap_count <= '0;
    end
  end

  // Sticky error flags; a new error in the clear cycle survives the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= '0;
    end else begin
      err_sticky <= (clear ? 3'b000 : err_sticky) | s_err;
    end
  end

  taxi_pulse_stretch #(
    .LEN(BLINK_CYCLES)
  ) u_act (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (gmii_rx_dv | gmii_tx_en),
    .out  (activity)
  );

  // Registered LED drive so the pins never see combinational glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 2'b00;
    end else begin
      led <= {link_up & activity, link_up};
    end
  end

endmodule

// File: tb/tb_taxi_basex_link_mon.sv
// Directed testbench for taxi_basex_link_mon (HOLDOFF 16, BLINK 8, CNT_W 4).
module tb_taxi_basex_link_mon;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] status_vect;
  logic        gmii_rx_dv;
  logic        gmii_tx_en;
  logic        clear;
  logic        link_up;
  logic        link_up_event;
  logic        link_down_event;
  logic [3:0]  flap_count;
  logic [2:0]  err_sticky;
  logic        activity;
  logic [1:0]  led;

  int vec_count = 0;
  int err_count = 0;

  taxi_basex_link_mon #(
    .HOLDOFF_CYCLES(16),
    .BLINK_CYCLES  (8),
    .CNT_W         (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .status_vect    (status_vect),
    .gmii_rx_dv     (gmii_rx_dv),
    .gmii_tx_en     (gmii_tx_en),
    .clear          (clear),
    .link_up        (link_up),
    .link_up_event  (link_up_event),
    .link_down_event(link_down_event),
    .flap_count     (flap_count),
    .err_sticky     (err_sticky),
    .activity       (activity),
    .led            (led)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    status_vect = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    status_vect = 16'h0000;
    gmii_rx_dv = 1'b0;
    gmii_tx_en = 1'b0;
    clear = 1'b0;
    #2;
    vec_count++;
    if ({link_up, link_up_event, link_down_event, flap_count, err_sticky, activity, led} !== 13'b0) begin
      err_count++;
      $display("[TB] FAIL reset_outputs got %b expected 0",
               {link_up, link_up_event, link_down_event, flap_count, err_sticky, activity, led});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vec_count++;
    if (link_up !== 1'b0 || flap_count !== 4'd0) begin
      err_count++;
      $display("[TB] FAIL reset_release link_up=%b flap=%0d expected 0/0", link_up, flap_count);
    end
  endtask

  task automatic test_qualify();
    status_vect[0] = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      vec_count++;
      if (link_up !== (k >= 18) || link_up_event !== (k == 18)) begin
        err_count++;
        $display("[TB] FAIL qualify cycle %0d link_up=%b event=%b expected %b/%b",
                 k, link_up, link_up_event, (k >= 18), (k == 18));
      end
    end
    vec_count++;
    if (flap_count !== 4'd0 || led !== 2'b01) begin
      err_count++;
      $display("[TB] FAIL qualify_flap_led flap=%0d led=%b expected 0/01", flap_count, led);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    status_vect[0] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) status_vect[0] = 1'b0;
      if (k == 11) status_vect[0] = 1'b1;
      vec_count++;
      if (link_up !== 1'b0 || link_up_event !== 1'b0 || link_down_event !== 1'b0) begin
        err_count++;
        $display("[TB] FAIL glitch_first cycle %0d up=%b upev=%b dnev=%b expected 0/0/0",
                 k, link_up, link_up_event, link_down_event);
      end
    end
    for (int k = 1; k <= 18; k++) begin
      tick();
      vec_count++;
      if (link_up !== (k == 18) || link_up_event !== (k == 18)) begin
        err_count++;
        $display("[TB] FAIL glitch_requal cycle %0d link_up=%b event=%b expected %b/%b",
                 k, link_up, link_up_event, (k == 18), (k == 18));
      end
    end
    vec_count++;
    if (flap_count !== 4'd0) begin
      err_count++;
      $display("[TB] FAIL glitch_flap got %0d expected 0", flap_count);
    end
  endtask

  task automatic test_drop_saturate();
    int exp_flap;
    for (int d = 1; d <= 17; d++) begin
      exp_flap = (d > 15) ? 15 : d;
      status_vect[0] = 1'b0;
      for (int t = 1; t <= 3; t++) begin
        tick();
        vec_count++;
        if (link_up !== (t < 3) || link_down_event !== (t == 3)) begin
          err_count++;
          $display("[TB] FAIL drop %0d cycle %0d link_up=%b down_event=%b expected %b/%b",
                   d, t, link_up, link_down_event, (t < 3), (t == 3));
        end
      end
      vec_count++;
      if (flap_count !== 4'(exp_flap)) begin
        err_count++;
        $display("[TB] FAIL flap_count after drop %0d got %0d expected %0d", d, flap_count, exp_flap);
      end
      status_vect[0] = 1'b1;
      repeat (17) tick();
      vec_count++;
      if (link_up !== 1'b0) begin
        err_count++;
        $display("[TB] FAIL requal_early drop %0d link_up=%b expected 0", d, link_up);
      end
      tick();
      vec_count++;
      if (link_up !== 1'b1 || link_up_event !== 1'b1) begin
        err_count++;
        $display("[TB] FAIL requal drop %0d link_up=%b event=%b expected 1/1", d, link_up, link_up_event);
      end
    end
  endtask

  task automatic test_sticky_clear();
    vec_count++;
    if (err_sticky !== 3'b000) begin
      err_count++;
      $display("[TB] FAIL sticky_initial got %b expected 000", err_sticky);
    end
    status_vect[5] = 1'b1;
    tick();
    status_vect[5] = 1'b0;
    tick();
    vec_count++;
    if (err_sticky !== 3'b000) begin
      err_count++;
      $display("[TB] FAIL sticky_early got %b expected 000", err_sticky);
    end
    tick();
    vec_count++;
    if (err_sticky !== 3'b010) begin
      err_count++;
      $display("[TB] FAIL sticky_set got %b expected 010", err_sticky);
    end
    repeat (4) tick();
    vec_count++;
    if (err_sticky !== 3'b010) begin
      err_count++;
      $display("[TB] FAIL sticky_hold got %b expected 010", err_sticky);
    end
    // clear lands on the cycle the synced disperr is high
    status_vect[5] = 1'b1;
    tick();
    status_vect[5] = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vec_count++;
    if (err_sticky !== 3'b010 || flap_count !== 4'd0) begin
      err_count++;
      $display("[TB] FAIL sticky_collision err=%b flap=%0d expected 010/0", err_sticky, flap_count);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vec_count++;
    if (err_sticky !== 3'b000) begin
      err_count++;
      $display("[TB] FAIL sticky_clear got %b expected 000", err_sticky);
    end
    status_vect[4] = 1'b1;
    status_vect[6] = 1'b1;
    tick();
    status_vect[4] = 1'b0;
    status_vect[6] = 1'b0;
    repeat (3) tick();
    vec_count++;
    if (err_sticky !== 3'b101) begin
      err_count++;
      $display("[TB] FAIL sticky_map got %b expected 101", err_sticky);
    end
  endtask

  task automatic test_activity();
    gmii_rx_dv = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) gmii_rx_dv = 1'b0;
      vec_count++;
      if (activity !== (k <= 8) || led !== {(k >= 2 && k <= 9), 1'b1}) begin
        err_count++;
        $display("[TB] FAIL activity cycle %0d act=%b led=%b expected %b/%b",
                 k, activity, led, (k <= 8), {(k >= 2 && k <= 9), 1'b1});
      end
    end
    gmii_tx_en = 1'b1;
    repeat (12) tick();
    vec_count++;
    if (activity !== 1'b1 || led !== 2'b11) begin
      err_count++;
      $display("[TB] FAIL activity_held act=%b led=%b expected 1/11", activity, led);
    end
    gmii_tx_en = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      tick();
      vec_count++;
      if (activity !== (j <= 7)) begin
        err_count++;
        $display("[TB] FAIL activity_tail cycle %0d act=%b expected %b", j, activity, (j <= 7));
      end
    end
  endtask

  task automatic test_async_reset();
    for (int d = 1; d <= 3; d++) begin
      status_vect[0] = 1'b0;
      repeat (3) tick();
      status_vect[0] = 1'b1;
      repeat (18) tick();
    end
    tick();
    vec_count++;
    if (link_up !== 1'b1 || flap_count !== 4'd3 || err_sticky !== 3'b101 || led !== 2'b01) begin
      err_count++;
      $display("[TB] FAIL pre_reset up=%b flap=%0d err=%b led=%b expected 1/3/101/01",
               link_up, flap_count, err_sticky, led);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vec_count++;
    if (link_up !== 1'b0 || led !== 2'b00 || flap_count !== 4'd0 || err_sticky !== 3'b000) begin
      err_count++;
      $display("[TB] FAIL async_reset up=%b led=%b flap=%0d err=%b expected all 0",
               link_up, led, flap_count, err_sticky);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      vec_count++;
      if (link_up !== (k == 18) || link_up_event !== (k == 18)) begin
        err_count++;
        $display("[TB] FAIL post_reset_requal cycle %0d link_up=%b event=%b expected %b/%b",
                 k, link_up, link_up_event, (k == 18), (k == 18));
      end
    end
  endtask

  initial begin
    test_reset();
    test_qualify();
    test_glitch();
    test_drop_saturate();
    test_sticky_clear();
    test_activity();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
